// File: rtl/gpio_filter_pkg.sv
// Shared register map, mode encodings and reset constants for the GPIO input filter block.
package gpio_filter_pkg;

  localparam logic [1:0] ADDR_DIV   = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_MODE  = 2'd2;
  localparam logic [1:0] ADDR_FLAGS = 2'd3;

  localparam logic MODE_BCAST = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam logic [7:0] MASK_RST = 8'hFF;
  localparam logic [1:0] PIPE_RST = 2'b11;

endpackage

// File: rtl/gpio_filter_chan.sv
// One glitch-filter channel: two-sample pipe, filtered level and registered edge pulses.
module gpio_filter_chan
  import gpio_filter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic ena,
  input  logic din,
  output logic dout,
  output logic pos_edge,
  output logic neg_edge
);

  logic [1:0] pipe_reg;
  logic       dout_reg;
  logic       dout_next;
  logic       pos_reg;
  logic       neg_reg;

  // Level only changes once two consecutive enabled samples agree.
  always_comb begin
    dout_next = dout_reg;
    if (pipe_reg == 2'b00) begin
      dout_next = 1'b0;
    end else if (pipe_reg == 2'b11) begin
      dout_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_reg <= PIPE_RST;
      dout_reg <= 1'b1;
      pos_reg  <= 1'b0;
      neg_reg  <= 1'b0;
    end else begin
      if (ena) begin
        pipe_reg <= {pipe_reg[0], din};
      end
      dout_reg <= dout_next;
      pos_reg  <= dout_next & ~dout_reg;
      neg_reg  <= ~dout_next & dout_reg;
    end
  end

  assign dout     = dout_reg;
  assign pos_edge = pos_reg;
  assign neg_edge = neg_reg;

endmodule

// File: rtl/gpio_filter_ctrl.sv
// GPIO input conditioner: prescaler, broadcast/round-robin sample scheduling, sticky edge flags.
// Optional input synchronizer enabled by defining GPIO_FILTER_SYNC_EN.
module gpio_filter_ctrl
  import gpio_filter_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic [7:0]       cfg_rdata,
  input  logic [NCH-1:0]   din,
  output logic [NCH-1:0]   dout,
  output logic [NCH-1:0]   pos_edge,
  output logic [NCH-1:0]   neg_edge,
  output logic             irq
);

  localparam int              PTR_W    = 3;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NCH - 1);

  logic [DIV_W-1:0] div_reg, cnt_reg, cnt_next;
  logic [NCH-1:0]   mask_reg, flags_reg, flags_next, clr, ena, din_f;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic             mode_reg;
  logic             tick, wr_div, wr_mask, wr_mode, wr_flags;

  assign wr_div   = cfg_we && (cfg_addr == ADDR_DIV);
  assign wr_mask  = cfg_we && (cfg_addr == ADDR_MASK);
  assign wr_mode  = cfg_we && (cfg_addr == ADDR_MODE);
  assign wr_flags = cfg_we && (cfg_addr == ADDR_FLAGS);
  assign tick     = (cnt_reg == '0);

  always_comb begin
    cnt_next = cnt_reg - DIV_W'(1);
    if (wr_div) begin
      cnt_next = cfg_wdata[DIV_W-1:0];
    end else if (tick) begin
      cnt_next = div_reg;
    end
    ptr_next = ptr_reg;
    if (wr_mode) begin
      ptr_next = '0;
    end else if (tick) begin
      ptr_next = (ptr_reg == PTR_LAST) ? '0 : ptr_reg + PTR_W'(1);
    end
    clr        = wr_flags ? cfg_wdata[NCH-1:0] : '0;
    flags_next = (flags_reg & ~clr) | pos_edge | neg_edge;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg   <= '0;
      cnt_reg   <= '0;
      mask_reg  <= MASK_RST[NCH-1:0];
      mode_reg  <= MODE_BCAST;
      ptr_reg   <= '0;
      flags_reg <= '0;
    end else begin
      if (wr_div)  div_reg  <= cfg_wdata[DIV_W-1:0];
      if (wr_mask) mask_reg <= cfg_wdata[NCH-1:0];
      if (wr_mode) mode_reg <= cfg_wdata[0];
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      flags_reg <= flags_next;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_DIV:  cfg_rdata[DIV_W-1:0] = div_reg;
      ADDR_MASK: cfg_rdata[NCH-1:0]   = mask_reg;
      ADDR_MODE: cfg_rdata[0]         = mode_reg;
      default:   cfg_rdata[NCH-1:0]   = flags_reg;
    endcase
  end

  assign irq = |flags_reg;

`ifdef GPIO_FILTER_SYNC_EN
  logic [NCH-1:0] sync1_reg, sync2_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
    end
  end
  assign din_f = sync2_reg;
`else
  assign din_f = din;
`endif

  // In round-robin mode only the channel under the pointer is sampled on a tick.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign ena[gi] = tick & mask_reg[gi] &
                     ((mode_reg == MODE_BCAST) | (ptr_reg == PTR_W'(gi)));

    gpio_filter_chan u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .ena      (ena[gi]),
      .din      (din_f[gi]),
      .dout     (dout[gi]),
      .pos_edge (pos_edge[gi]),
      .neg_edge (neg_edge[gi])
    );
  end

endmodule

// File: tb/tb_gpio_filter_ctrl.sv
// Self-checking bench for gpio_filter_ctrl: register vectors, directed corner sequences, random run vs model.
module tb_gpio_filter_ctrl;
  import gpio_filter_pkg::*;

  localparam int NCH = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_addr = 2'd0;
  logic [7:0]     cfg_wdata = 8'd0;
  logic [7:0]     cfg_rdata;
  logic [NCH-1:0] din = '1;
  logic [NCH-1:0] dout, pos_edge, neg_edge;
  logic           irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpio_filter_ctrl #(.NCH(NCH), .DIV_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .din       (din),
    .dout      (dout),
    .pos_edge  (pos_edge),
    .neg_edge  (neg_edge),
    .irq       (irq)
  );

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[11];

  // Behavioural model state: last two enabled samples per channel and the register file.
  int             m_div, m_cnt, m_ptr;
  bit [NCH-1:0]   m_mask, m_dout, m_pos, m_neg, m_flags;
  bit             m_mode;
  bit             m_old[NCH];
  bit             m_new[NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    cyc();
    cfg_we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic model_reset();
    m_div = 0; m_cnt = 0; m_ptr = 0;
    m_mask = '1; m_mode = 1'b0;
    m_dout = '1; m_pos = '0; m_neg = '0; m_flags = '0;
    for (int i = 0; i < NCH; i++) begin
      m_old[i] = 1'b1;
      m_new[i] = 1'b1;
    end
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] a);
    case (a)
      2'd0: return 8'(m_div);
      2'd1: return m_mask;
      2'd2: return {7'd0, m_mode};
      default: return m_flags;
    endcase
  endfunction

  // Advance the model by one clock given the inputs present during the cycle.
  task automatic model_step(input logic [NCH-1:0] d, input logic we,
                            input logic [1:0] a, input logic [7:0] wd);
    bit           tick;
    bit [NCH-1:0] nd;
    bit [NCH-1:0] clr;
    tick = (m_cnt == 0);
    for (int i = 0; i < NCH; i++) begin
      nd[i] = (m_old[i] == m_new[i]) ? m_new[i] : m_dout[i];
    end
    clr     = (we && a == 2'd3) ? wd : 8'd0;
    m_flags = (m_flags & ~clr) | m_pos | m_neg;
    m_pos   = nd & ~m_dout;
    m_neg   = ~nd & m_dout;
    m_dout  = nd;
    for (int i = 0; i < NCH; i++) begin
      if (tick && m_mask[i] && (!m_mode || m_ptr == i)) begin
        m_old[i] = m_new[i];
        m_new[i] = d[i];
      end
    end
    if (we && a == 2'd0) m_cnt = int'(wd);
    else if (tick)       m_cnt = m_div;
    else                 m_cnt = m_cnt - 1;
    if (we && a == 2'd2) m_ptr = 0;
    else if (tick)       m_ptr = (m_ptr + 1) % NCH;
    if (we && a == 2'd0) m_div  = int'(wd);
    if (we && a == 2'd1) m_mask = wd;
    if (we && a == 2'd2) m_mode = wd[0];
  endtask

  initial begin
    logic [7:0] r;
    int         p;
    bit         tick;
    logic [7:0] exp_ena;

    vecs[0]  = '{1'b0, ADDR_DIV,   8'h00, 8'h00};
    vecs[1]  = '{1'b0, ADDR_MASK,  8'h00, 8'hFF};
    vecs[2]  = '{1'b0, ADDR_MODE,  8'h00, 8'h00};
    vecs[3]  = '{1'b0, ADDR_FLAGS, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, ADDR_DIV,   8'h5A, 8'h5A};
    vecs[5]  = '{1'b1, ADDR_MASK,  8'h3C, 8'h3C};
    vecs[6]  = '{1'b1, ADDR_MODE,  8'h03, 8'h01};
    vecs[7]  = '{1'b1, ADDR_MODE,  8'h00, 8'h00};
    vecs[8]  = '{1'b1, ADDR_FLAGS, 8'hFF, 8'h00};
    vecs[9]  = '{1'b1, ADDR_MASK,  8'hFF, 8'hFF};
    vecs[10] = '{1'b1, ADDR_DIV,   8'h00, 8'h00};

    repeat (3) cyc();
    reset_n = 1'b1;
    cyc();
    check("reset_dout", 32'(dout), 32'hFF);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_edges", 32'({pos_edge, neg_edge}), 32'h0);

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].we) wr(vecs[v].addr, vecs[v].wdata);
      rd(vecs[v].addr, r);
      check($sformatf("reg_vec%0d", v), 32'(r), 32'(vecs[v].exp));
      $display("[TB] vec %0d we=%0d addr=%0d wdata=0x%02h rdata=0x%02h", v, vecs[v].we,
               vecs[v].addr, vecs[v].wdata, r);
    end

    // Falling step on ch0: dout changes at the third edge, then flag and irq.
    din[0] = 1'b0;
    cyc(); check("step_e0_dout0", 32'(dout[0]), 32'h1);
    cyc(); check("step_e1_dout0", 32'(dout[0]), 32'h1);
    cyc(); check("step_e2_dout0", 32'(dout[0]), 32'h0);
    check("step_e2_neg", 32'(neg_edge), 32'h01);
    check("step_e2_pos", 32'(pos_edge), 32'h00);
    cyc(); check("step_e3_neg", 32'(neg_edge), 32'h00);
    rd(ADDR_FLAGS, r); check("step_flags", 32'(r), 32'h01);
    check("step_irq", 32'(irq), 32'h1);
    wr(ADDR_FLAGS, 8'h01);
    rd(ADDR_FLAGS, r); check("w1c_flags", 32'(r), 32'h00);
    check("w1c_irq", 32'(irq), 32'h0);
    $display("[TB] step sequence on ch0 done");

    // Single-cycle glitch on ch3 must be rejected.
    din[3] = 1'b0;
    cyc();
    din[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      check("glitch_dout3", 32'(dout[3]), 32'h1);
      check("glitch_edges", 32'({pos_edge, neg_edge}), 32'h0);
    end
    rd(ADDR_FLAGS, r); check("glitch_flags", 32'(r), 32'h00);
    $display("[TB] glitch sequence on ch3 done");

    // Round-robin with DIV=3; MODE rewrite mid-sequence restarts at ch0.
    wr(ADDR_DIV, 8'd3);
    wr(ADDR_MODE, 8'd1);
    p = 0;
    for (int k = 1; k <= 60; k++) begin
      cfg_we    = (k == 45);
      cfg_addr  = ADDR_MODE;
      cfg_wdata = 8'd1;
      tick      = (k >= 3) && ((k - 3) % 4 == 0);
      exp_ena   = tick ? 8'(1 << p) : 8'h00;
      check($sformatf("rr_ena_k%0d", k), 32'(dut.ena), 32'(exp_ena));
      if (k == 45) p = 0;
      else if (tick) p = (p + 1) % NCH;
      cyc();
    end
    cfg_we = 1'b0;
    wr(ADDR_MODE, 8'd0);
    wr(ADDR_DIV, 8'd0);
    $display("[TB] round-robin sequence done");

    // Masked ch0 ignores din, then resumes once unmasked.
    wr(ADDR_MASK, 8'hFE);
    for (int k = 0; k < 9; k++) begin
      din[0] = (k / 3) % 2 == 0;
      cyc();
      check("mask_dout0", 32'(dout[0]), 32'h0);
    end
    rd(ADDR_FLAGS, r); check("mask_flags", 32'(r), 32'h00);
    din[0] = 1'b1;
    wr(ADDR_MASK, 8'hFF);
    repeat (4) cyc();
    check("unmask_dout0", 32'(dout[0]), 32'h1);
    rd(ADDR_FLAGS, r); check("unmask_flags", 32'(r), 32'h01);
    wr(ADDR_FLAGS, 8'hFF);
    $display("[TB] mask sequence done");

    // Edge set and W1C clear on bit 2 in the same cycle: set wins.
    din[2] = 1'b0;
    repeat (4) cyc();
    rd(ADDR_FLAGS, r); check("sc_flags_pre", 32'(r), 32'h04);
    din[2] = 1'b1;
    repeat (3) cyc();
    check("sc_pos2", 32'(pos_edge), 32'h04);
    wr(ADDR_FLAGS, 8'h04);
    rd(ADDR_FLAGS, r); check("sc_flags_setwins", 32'(r), 32'h04);
    check("sc_irq", 32'(irq), 32'h1);
    wr(ADDR_FLAGS, 8'h04);
    rd(ADDR_FLAGS, r); check("sc_flags_clear", 32'(r), 32'h00);
    $display("[TB] set-vs-clear sequence done");

    // Asynchronous reset in the middle of a prescaler count.
    din[5] = 1'b0;
    repeat (4) cyc();
    wr(ADDR_DIV, 8'd5);
    cyc();
    cfg_addr = ADDR_DIV;
    check("ar_pre_dout", 32'(dout), 32'hDF);
    check("ar_pre_irq", 32'(irq), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_dout", 32'(dout), 32'hFF);
    check("ar_edges", 32'({pos_edge, neg_edge}), 32'h0);
    check("ar_irq", 32'(irq), 32'h0);
    check("ar_div", 32'(cfg_rdata), 32'h0);
    din = '1;
    repeat (2) cyc();
    reset_n = 1'b1;
    $display("[TB] async reset sequence done");

    // Random run against the model.
    model_reset();
    for (int b = 0; b < 20; b++) begin
      int nerr;
      nerr = n_fail;
      for (int c = 0; c < 100; c++) begin
        din      = din ^ NCH'($urandom & $urandom & $urandom);
        cfg_addr = 2'($urandom_range(0, 3));
        cfg_we   = ($urandom_range(0, 15) == 0);
        cfg_wdata = (cfg_addr == ADDR_DIV) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        #1;
        check("rand_rdata", 32'(cfg_rdata), 32'(model_read(cfg_addr)));
        model_step(din, cfg_we, cfg_addr, cfg_wdata);
        cyc();
        check("rand_outputs", 32'({irq, pos_edge, neg_edge, dout}),
              32'({|m_flags, m_pos, m_neg, m_dout}));
      end
      cfg_we = 1'b0;
      $display("[TB] random burst %0d: 100 cycles, %0d new errors", b, n_fail - nerr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
